// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell, registered borrow.
// Optional signed-overflow flag on port ovf when SERIAL_SUB_OVF_EN is defined.
module serial_sub #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bw_q, bw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH+1:0] out_q, out_d;
  logic             bit_d;
  logic             bw_n;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  always_comb begin
    bit_d = a_q[0] ^ b_q[0] ^ bw_q;
    bw_n  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bw_d    = bw_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          bw_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        diff_d = {bit_d, diff_q[WIDTH-1:1]};
        bw_d   = bw_n;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          out_d   = {1'b0, bw_n, bit_d, diff_q[WIDTH-1:1]};
`ifdef SERIAL_SUB_OVF_EN
          // Borrow into the sign bit differs from borrow out of it.
          ovf_d   = bw_q ^ bw_n;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bw_q    <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bw_q    <= bw_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: two instances (WIDTH=2 and WIDTH=4), directed steps plus
// a randomized run checked against an arithmetic reference model.
module tb_serial_sub;

  logic clk;
  logic rst;

  logic       in_valid2, in_ready2, out_valid2, out_ready2;
  logic [1:0] a2, b2;
  logic [3:0] out2;
  logic       in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0] a4, b4;
  logic [5:0] out4;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf2, ovf4;
`endif

  int tests = 0;
  int fails = 0;
  int issued = 0;
  int consumed = 0;
  logic [31:0] exp_q[$];

  serial_sub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out(out2)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf2)
`endif
  );

  serial_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out(out4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: borrow = unsigned a < b, diff = (a - b) mod 2^w, MSB zero.
  function automatic logic [31:0] model_out(input int w, input int av, input int bv);
    int m;
    m = (1 << w) - 1;
    return 32'(((av < bv) ? (1 << w) : 0) | ((av - bv) & m));
  endfunction

  // Reference: signed a - b falls outside the w-bit two's-complement range.
  function automatic logic [31:0] model_ovf(input int w, input int av, input int bv);
    int sa, sb, r, half;
    half = 1 << (w - 1);
    sa = (av >= half) ? av - (1 << w) : av;
    sb = (bv >= half) ? bv - (1 << w) : bv;
    r = sa - sb;
    return (r < -half || r > half - 1) ? 32'd1 : 32'd0;
  endfunction

  task automatic drive(input int w, input bit iv, input int av, input int bv, input bit ordy);
    if (w == 2) begin
      in_valid2 = iv; a2 = av[1:0]; b2 = bv[1:0]; out_ready2 = ordy;
    end else begin
      in_valid4 = iv; a4 = av[3:0]; b4 = bv[3:0]; out_ready4 = ordy;
    end
  endtask

  function automatic logic [31:0] rdy(input int w);
    return (w == 2) ? 32'(in_ready2) : 32'(in_ready4);
  endfunction
  function automatic logic [31:0] vld(input int w);
    return (w == 2) ? 32'(out_valid2) : 32'(out_valid4);
  endfunction
  function automatic logic [31:0] outv(input int w);
    return (w == 2) ? 32'(out2) : 32'(out4);
  endfunction
`ifdef SERIAL_SUB_OVF_EN
  function automatic logic [31:0] ovfv(input int w);
    return (w == 2) ? 32'(ovf2) : 32'(ovf4);
  endfunction
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, wait for result, hold for 'stall' cycles
  // (with stray operands offered meanwhile), then consume.
  task automatic run_op(input int w, input int av, input int bv, input int stall);
    int n;
    logic [31:0] exp;
    logic [31:0] exp_ovf;
    exp_ovf = model_ovf(w, av, bv);
    n = 0;
    while (rdy(w) !== 32'd1 && n < 50) begin tick(); n++; end
    check("in_ready_before_accept", rdy(w), 32'd1);
    drive(w, 1'b1, av, bv, stall == 0);
    exp_q.push_back(model_out(w, av, bv));
    issued++;
    tick();
    drive(w, 1'b0, int'($urandom), int'($urandom), stall == 0);
    n = 0;
    while (vld(w) !== 32'd1 && n < 50) begin tick(); n++; end
    check("latency_cycles", 32'(n), 32'(w));
    check("in_ready_in_done", rdy(w), 32'd0);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
      consumed++;
    end
    check("out_at_done", outv(w), exp);
`ifdef SERIAL_SUB_OVF_EN
    check("ovf_at_done", ovfv(w), exp_ovf);
`endif
    for (int k = 0; k < stall; k++) begin
      drive(w, 1'b1, 0, 1, 1'b0);
      tick();
      check("stall_out_valid", vld(w), 32'd1);
      check("stall_out_stable", outv(w), exp);
      check("stall_in_ready", rdy(w), 32'd0);
    end
    drive(w, 1'b0, 0, 0, 1'b1);
    tick();
    check("consumed_out_valid", vld(w), 32'd0);
    check("in_ready_after_consume", rdy(w), 32'd1);
    check("out_kept_after_consume", outv(w), exp);
    drive(w, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive(2, 1'b0, 0, 0, 1'b0);
    drive(4, 1'b0, 0, 0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    check("reset_out2", 32'(out2), 32'd0);
    check("reset_valid2", 32'(out_valid2), 32'd0);
    check("reset_ready2", 32'(in_ready2), 32'd1);
    check("reset_out4", 32'(out4), 32'd0);
    check("reset_ready4", 32'(in_ready4), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf4", 32'(ovf4), 32'd0);
`endif

    // WIDTH=2 directed cases, including a long stall with stray operands.
    run_op(2, 3, 1, 0);
    run_op(2, 1, 2, 0);
    run_op(2, 2, 2, 0);
    run_op(2, 3, 2, 5);
    run_op(2, 0, 3, 1);
    run_op(2, 2, 1, 0);

    // WIDTH=4 directed: overflow cases and boundary values.
    run_op(4, 5, 9, 0);
    check("dir_5_minus_9", 32'(out4), 32'h1C);
    run_op(4, 7, 2, 0);
    check("dir_7_minus_2", 32'(out4), 32'h05);
    run_op(4, 0, 15, 2);
    run_op(4, 15, 15, 0);
    run_op(4, 8, 1, 1);

    // Reset during the second SHIFT cycle discards the operation.
    drive(4, 1'b1, 9, 5, 1'b1);
    tick();
    drive(4, 1'b0, 0, 0, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midop_rst_out", 32'(out4), 32'd0);
    check("midop_rst_valid", 32'(out_valid4), 32'd0);
    check("midop_rst_ready", 32'(in_ready4), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
    check("midop_rst_ovf", 32'(ovf4), 32'd0);
`endif
    drive(4, 1'b0, 0, 0, 1'b0);
    tick();
    check("midop_no_result", 32'(out_valid4), 32'd0);
    run_op(4, 9, 5, 0);
    check("after_rst_9_minus_5", 32'(out4), 32'h04);

    // Randomized run with random stalls and idle gaps.
    for (int i = 0; i < 200; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
      run_op(4, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 40; i++) begin
      run_op(2, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)));
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("issued_vs_consumed", 32'(consumed), 32'(issued));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
